// File: rtl/ber_pkg.sv
// Shared definitions for the BER meter: FSM encodings and popcount sizing.
package ber_pkg;

    // Top-level FSM states
    localparam logic [0:0] ST_SEARCH  = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Width needed to hold the number of set bits in a w-bit word
    function automatic int pc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count of one raw word.
module ber_popcount
    import ber_pkg::*;
#(
    parameter int W   = 8,
    parameter int PCW = pc_width(W)
) (
    input  logic [W-1:0]   din,
    output logic [PCW-1:0] count
);

    logic [PCW-1:0] sum_s;

    // Per-bit sum; synthesis rebalances the chain into an adder tree
    always_comb begin
        sum_s = {PCW{1'b0}};
        for (int i = 0; i < W; i++) begin
            sum_s = sum_s + PCW'(din[i]);
        end
        count = sum_s;
    end

endmodule

// File: rtl/ber_align_meter.sv
// Bit-error-rate meter with automatic word-delay search between the
// transmitted and received raw streams of the comm loopback path.
// Three-stage pipeline: XOR, popcount, accumulate.  A stage-0 word
// counter tags the last word of each dwell/window; the decision is taken
// when that tag reaches the accumulator stage.
module ber_align_meter
    import ber_pkg::*;
#(
    parameter int W            = 8,
    parameter int MAX_DELAY    = 16,
    parameter int DELAY_W      = 4,
    parameter int SEARCH_WORDS = 64,
    parameter int WINDOW       = 1024,
    parameter int LOCK_THRESH  = 0,
    parameter int LOSS_THRESH  = 64,
    parameter int CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               valid_i,
    input  logic [W-1:0]       sent_data,
    input  logic [W-1:0]       recv_data,
    input  logic               start,
    input  logic               manual_en,
    input  logic [DELAY_W-1:0] manual_delay,
    output logic [DELAY_W-1:0] delay_o,
    output logic               locked,
    output logic               search_fail,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   bit_count,
    output logic               result_valid
);

    localparam int PCW     = pc_width(W);
    localparam int LEN_MAX = (WINDOW > SEARCH_WORDS) ? WINDOW : SEARCH_WORDS;
    localparam int CW      = $clog2(LEN_MAX + 1);

    localparam logic [CW-1:0]      WIN_LAST     = CW'(WINDOW - 1);
    localparam logic [CW-1:0]      DWELL_LEN    = CW'(SEARCH_WORDS);
    localparam logic [CW-1:0]      DWELL_LAST   = CW'(SEARCH_WORDS - 1);
    localparam logic [DELAY_W-1:0] DELAY_LAST   = DELAY_W'(MAX_DELAY - 1);
    localparam logic [CNT_W-1:0]   BITS_PER_WIN = CNT_W'(WINDOW * W);
    localparam logic [CNT_W-1:0]   LOCK_LIM     = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0]   LOSS_LIM     = CNT_W'(LOSS_THRESH);

    // Saturating accumulate: sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PCW-1:0]   b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W + 1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // line_r[k] holds the word sent k+1 valid words ago (tap 0 is sent_data)
    logic [W-1:0]   line_r [MAX_DELAY-1];
    logic [W-1:0]   tap_s;

    logic [0:0]     state_r;
    logic           manual_q_r;
    logic [CW-1:0]  cnt_r;
    logic [CNT_W-1:0] acc_r;

    logic [W-1:0]   xor_r;
    logic           v0_r;
    logic           last0_r;
    logic [PCW-1:0] pc_s;
    logic [PCW-1:0] pc_r;
    logic           v1_r;
    logic           last1_r;

    logic           abort_s;
    logic           issue_s;
    logic           last_s;
    logic           end_s;
    logic [CNT_W-1:0] acc_sum_s;
    logic           lock_ok_s;
    logic           loss_s;
    logic           drop_s;
    logic           flush_s;

    assign abort_s   = start | (manual_en != manual_q_r);
    assign end_s     = v1_r & last1_r;
    assign acc_sum_s = sat_add(acc_r, pc_r);
    assign lock_ok_s = (acc_sum_s <= LOCK_LIM);
    assign loss_s    = (acc_sum_s > LOSS_LIM);
    assign drop_s    = end_s & (state_r == ST_MEASURE) & loss_s & ~manual_q_r;
    assign flush_s   = abort_s | (end_s & (state_r == ST_SEARCH)) | drop_s;

    // Sent-word delay line, advanced on every valid word in every state
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < MAX_DELAY - 1; k++) begin
                line_r[k] <= {W{1'b0}};
            end
        end else if (valid_i) begin
            line_r[0] <= sent_data;
            for (int k = 1; k < MAX_DELAY - 1; k++) begin
                line_r[k] <= line_r[k-1];
            end
        end
    end

    // Select the delay-line tap for the currently applied delay
    always_comb begin
        tap_s = sent_data;
        if (delay_o != {DELAY_W{1'b0}}) begin
            tap_s = line_r[delay_o - 1'b1];
        end else begin
            tap_s = sent_data;
        end
    end

    // Decide whether this word counts and whether it closes a dwell/window;
    // a finished dwell stops counting until its decision resets the counter
    always_comb begin
        issue_s = 1'b0;
        last_s  = 1'b0;
        if (valid_i && !abort_s) begin
            if (state_r == ST_MEASURE) begin
                issue_s = 1'b1;
                last_s  = (cnt_r == WIN_LAST);
            end else if (cnt_r < DWELL_LEN) begin
                issue_s = 1'b1;
                last_s  = (cnt_r == DWELL_LAST);
            end else begin
                issue_s = 1'b0;
                last_s  = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    ber_popcount #(.W(W), .PCW(PCW)) u_popcount (
        .din   (xor_r),
        .count (pc_s)
    );

    // XOR and popcount pipeline stages; flush drops words of a stale delay
    always_ff @(posedge CLK) begin
        if (RST) begin
            xor_r   <= {W{1'b0}};
            v0_r    <= 1'b0;
            last0_r <= 1'b0;
            pc_r    <= {PCW{1'b0}};
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end else begin
            xor_r   <= recv_data ^ tap_s;
            v0_r    <= issue_s & ~flush_s;
            last0_r <= last_s;
            pc_r    <= pc_s;
            v1_r    <= v0_r & ~flush_s;
            last1_r <= last0_r;
        end
    end

    // Word counter, accumulator, FSM and registered results
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= manual_en ? ST_MEASURE : ST_SEARCH;
            manual_q_r   <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            acc_r        <= {CNT_W{1'b0}};
            delay_o      <= {DELAY_W{1'b0}};
            locked       <= 1'b0;
            search_fail  <= 1'b0;
            err_count    <= {CNT_W{1'b0}};
            bit_count    <= {CNT_W{1'b0}};
            result_valid <= 1'b0;
        end else begin
            search_fail  <= 1'b0;
            result_valid <= 1'b0;
            if (abort_s) begin
                manual_q_r <= manual_en;
                state_r    <= manual_en ? ST_MEASURE : ST_SEARCH;
                delay_o    <= manual_en ? manual_delay : {DELAY_W{1'b0}};
                locked     <= 1'b0;
                cnt_r      <= {CW{1'b0}};
                acc_r      <= {CNT_W{1'b0}};
            end else begin
                // stage 0: word counting, manual delay reload at window start
                if (issue_s) begin
                    if (last_s && (state_r == ST_MEASURE)) begin
                        cnt_r <= {CW{1'b0}};
                        if (manual_q_r) begin
                            delay_o <= manual_delay;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                // stage 2: accumulate
                if (v1_r) begin
                    acc_r <= acc_sum_s;
                end
                // stage 2: dwell / window decision
                if (end_s) begin
                    acc_r <= {CNT_W{1'b0}};
                    if (state_r == ST_SEARCH) begin
                        cnt_r <= {CW{1'b0}};
                        if (lock_ok_s) begin
                            locked  <= 1'b1;
                            state_r <= ST_MEASURE;
                        end else if (delay_o == DELAY_LAST) begin
                            search_fail <= 1'b1;
                            delay_o     <= {DELAY_W{1'b0}};
                        end else begin
                            delay_o <= delay_o + 1'b1;
                        end
                    end else begin
                        err_count    <= acc_sum_s;
                        bit_count    <= BITS_PER_WIN;
                        result_valid <= 1'b1;
                        if (drop_s) begin
                            locked  <= 1'b0;
                            state_r <= ST_SEARCH;
                            delay_o <= {DELAY_W{1'b0}};
                            cnt_r   <= {CW{1'b0}};
                        end
                    end
                end
            end
        end
    end

endmodule
